cgia_line_fetcher: RTL and testbench

Parametrised CGIA framebuffer fetcher. On each HSYNC rising edge with display enabled it bursts a programmable number of words from video memory over a classic single-outstanding bus master and writes them into an internal show-ahead FIFO for the pixel shifter. Each line's start address advances by a programmable stride. VSYNC reloads the frame base, aborts any fetch and flushes the FIFO.

---
 rtl/cgia_line_fetcher.sv | 189 ++++++++++++++++++
 tb/tb_cgia_line_fetcher.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgia_line_fetcher.sv
// ---------------------------------------------------------------------------
// cgia_line_fetcher
//
// Framebuffer line fetcher for the CGIA pixel pipeline. A rising HSYNC edge
// with display enabled starts a burst of len_i words from video memory. The
// burst uses a single-outstanding bus master. The words go into a show-ahead
// FIFO that feeds the pixel shifter. Each line's start address advances by
// stride_i. VSYNC reloads the frame base, aborts any fetch and flushes the
// FIFO.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   hsync_i, vsync_i          CRTC syncs (active high)
//   den_i                     display enable
//   fb_adr_i                  frame base word address [AW:1]
//   len_i                     words per line (0 = fetch nothing)
//   stride_i                  line-to-line increment in words
//   adr_o, cyc_o, stb_o       bus master request
//   ack_i, dat_i              bus master response
//   fifo_dat_o, fifo_valid_o  FIFO head word and non-empty flag
//   fifo_rd_i                 pop FIFO head (ignored when empty)
//   line_done_o               one-cycle pulse on the last ack of a line
//   overrun_o                 sticky: HSYNC edge arrived while still fetching
// ---------------------------------------------------------------------------
module cgia_line_fetcher #(
  parameter int AW        = 23,
  parameter int DW        = 16,
  parameter int LEN_W     = 10,
  parameter int FIFO_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             den_i,
  input  logic [AW-1:0]    fb_adr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [LEN_W-1:0] stride_i,
  output logic [AW-1:0]    adr_o,
  output logic             cyc_o,
  output logic             stb_o,
  input  logic             ack_i,
  input  logic [DW-1:0]    dat_i,
  output logic [DW-1:0]    fifo_dat_o,
  output logic             fifo_valid_o,
  input  logic             fifo_rd_i,
  output logic             line_done_o,
  output logic             overrun_o
);

  localparam int                DEPTH   = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DEPTH_C = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [AW-1:0]        adr_reg;
  logic [AW-1:0]        line_adr_reg;
  logic [LEN_W-1:0]     rem_reg;
  logic                 hs_q_reg;
  logic                 line_done_reg;
  logic                 overrun_reg;

  logic [DW-1:0]        mem_reg [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_LOG2:0]   count_reg, count_next;

  logic hs_edge, start, full, push, pop, last;

  assign hs_edge = hsync_i & ~hs_q_reg;
  assign start   = hs_edge & den_i & ~vsync_i & (state_reg == IDLE) & (len_i != '0);
  assign full    = (count_reg == DEPTH_C);
  assign pop     = fifo_rd_i & (count_reg != '0) & ~vsync_i;
  // A word is only accepted when it has somewhere to go; a same-cycle pop
  // frees the slot it needs.
  assign push    = (state_reg == FETCH) & ack_i & ~vsync_i & (~full | pop);
  assign last    = push & (rem_reg == LEN_W'(1));

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (FIFO_LOG2 + 1)'(1);
      2'b01:   count_next = count_reg - (FIFO_LOG2 + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (vsync_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        // A line that starts while the FIFO is full waits in PAUSE, so
        // FETCH is never entered without space.
        IDLE:    if (start) state_next = (count_next == DEPTH_C) ? PAUSE : FETCH;
        FETCH: begin
          if (last)                                 state_next = IDLE;
          else if (push && (count_next == DEPTH_C)) state_next = PAUSE;
        end
        PAUSE:   if (!full) state_next = FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cyc_o = (state_reg == FETCH);
    stb_o = (state_reg == FETCH);
  end

  // ---------------- address / count datapath ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      adr_reg       <= '0;
      line_adr_reg  <= '0;
      rem_reg       <= '0;
      hs_q_reg      <= 1'b0;
      line_done_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      hs_q_reg      <= hsync_i;
      line_done_reg <= 1'b0;
      if (vsync_i) begin
        line_adr_reg <= fb_adr_i;
        adr_reg      <= fb_adr_i;
        rem_reg      <= '0;
        overrun_reg  <= 1'b0;
      end else begin
        if (start) begin
          adr_reg <= line_adr_reg;
          rem_reg <= len_i;
        end
        if (hs_edge && den_i && (state_reg != IDLE))
          overrun_reg <= 1'b1;
        if (push) begin
          adr_reg <= adr_reg + AW'(1);
          rem_reg <= rem_reg - LEN_W'(1);
          if (last) begin
            line_done_reg <= 1'b1;
            line_adr_reg  <= line_adr_reg + AW'(stride_i);
          end
        end
      end
    end
  end

  // ---------------- FIFO pointers ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (vsync_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_LOG2'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_LOG2'(1);
      count_reg <= count_next;
    end
  end

  // FIFO storage. The head is read combinationally so that the word sits
  // at the output as soon as it is written (show-ahead).
  always_ff @(posedge clk_i) begin
    if (push) mem_reg[wr_ptr_reg] <= dat_i;
  end

  assign fifo_dat_o   = mem_reg[rd_ptr_reg];
  assign fifo_valid_o = (count_reg != '0);
  assign adr_o        = adr_reg;
  assign line_done_o  = line_done_reg;
  assign overrun_o    = overrun_reg;

endmodule

// File: tb/tb_cgia_line_fetcher.sv
module tb_cgia_line_fetcher;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int LW = 10;
  localparam int FL = 2;   // depth 4 so backpressure is easy to reach

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          hsync_i, vsync_i, den_i;
  logic [AW-1:0] fb_adr_i;
  logic [LW-1:0] len_i, stride_i;
  logic [AW-1:0] adr_o;
  logic          cyc_o, stb_o, ack_i;
  logic [DW-1:0] dat_i, fifo_dat_o;
  logic          fifo_valid_o, fifo_rd_i, line_done_o, overrun_o;
  logic          ack_gate;

  int n_checks = 0;
  int n_fail   = 0;
  int ld_count = 0;
  int got_n;
  logic [DW-1:0] got [0:63];

  cgia_line_fetcher #(.AW(AW), .DW(DW), .LEN_W(LW), .FIFO_LOG2(FL)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .den_i(den_i), .fb_adr_i(fb_adr_i), .len_i(len_i), .stride_i(stride_i),
    .adr_o(adr_o), .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .dat_i(dat_i),
    .fifo_dat_o(fifo_dat_o), .fifo_valid_o(fifo_valid_o), .fifo_rd_i(fifo_rd_i),
    .line_done_o(line_done_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: each word's content is derived from its address.
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  assign ack_i = stb_o & ack_gate;
  assign dat_i = word_of(adr_o);

  always @(negedge clk_i) if (line_done_o === 1'b1) ld_count <= ld_count + 1;

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_vsync(input logic [AW-1:0] base);
    fb_adr_i = base;
    vsync_i  = 1'b1;
    step();
    vsync_i  = 1'b0;
  endtask

  task automatic hsync_pulse();
    hsync_i = 1'b1;
    step();
    hsync_i = 1'b0;
  endtask

  // Pops every word that shows up during a fixed number of cycles.
  task automatic pop_all(input int cycles);
    got_n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (fifo_valid_o === 1'b1 && got_n < 64) begin
        got[got_n] = fifo_dat_o;
        got_n++;
        fifo_rd_i = 1'b1;
      end else begin
        fifo_rd_i = 1'b0;
      end
      step();
    end
    fifo_rd_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %0b want 0", cyc_o); end
    n_checks++; if (stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %0b want 0", stb_o); end
    n_checks++; if (adr_o !== '0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", adr_o); end
    n_checks++; if (fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", fifo_valid_o); end
    n_checks++; if ({line_done_o, overrun_o} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {line_done_o, overrun_o}); end
    step(); step();
    reset_i = 1'b0;
    step();
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    int ld0;
    ld0 = ld_count;
    len_i = 10'd4; stride_i = 10'h40; ack_gate = 1'b1;
    do_vsync(23'h1000);
    n_checks++; if (adr_o !== 23'h1000) begin n_fail++; $display("FAIL basic_vsync_adr: got %h want 1000", adr_o); end
    hsync_pulse();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (adr_o !== 23'h1000 + 23'(k) || stb_o !== 1'b1) begin
        n_fail++; $display("FAIL basic_adr%0d: got %h stb %0b want %h stb 1", k, adr_o, stb_o, 23'h1000 + 23'(k));
      end
      step();
    end
    n_checks++; if (line_done_o !== 1'b1 || cyc_o !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done %0b cyc %0b want 1 0", line_done_o, cyc_o); end
    step();
    n_checks++; if (line_done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %0b want 0", line_done_o); end
    pop_all(8);
    n_checks++; if (got_n != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", got_n); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (got[k] !== word_of(23'h1000 + 23'(k))) begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", k, got[k], word_of(23'h1000 + 23'(k))); end
    end
    n_checks++; if (ld_count - ld0 != 1) begin n_fail++; $display("FAIL basic_ld_count: got %0d want 1", ld_count - ld0); end
    hsync_pulse();
    n_checks++; if (adr_o !== 23'h1040 || cyc_o !== 1'b1) begin n_fail++; $display("FAIL basic_stride: got %h cyc %0b want 1040 1", adr_o, cyc_o); end
    pop_all(10);
    n_checks++; if (got_n != 4 || got[0] !== word_of(23'h1040)) begin n_fail++; $display("FAIL basic_line2: got n=%0d w0=%h want n=4 w0=%h", got_n, got[0], word_of(23'h1040)); end
    $display("test_basic: done");
  endtask

  task automatic test_backpressure();
    int ld0;
    ld0 = ld_count;
    len_i = 10'd10; stride_i = 10'h40; ack_gate = 1'b1;
    do_vsync(23'h1000);
    hsync_pulse();
    repeat (4) step();
    n_checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin n_fail++; $display("FAIL bp_pause: got cyc %0b stb %0b want 0 0", cyc_o, stb_o); end
    n_checks++; if (adr_o !== 23'h1004) begin n_fail++; $display("FAIL bp_adr: got %h want 1004", adr_o); end
    step(); step();
    n_checks++; if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got %0b want 0", cyc_o); end
    n_checks++; if (fifo_dat_o !== word_of(23'h1000)) begin n_fail++; $display("FAIL bp_head: got %h want %h", fifo_dat_o, word_of(23'h1000)); end
    fifo_rd_i = 1'b1;
    step();
    fifo_rd_i = 1'b0;
    n_checks++; if (stb_o !== 1'b0) begin n_fail++; $display("FAIL bp_pop_edge: got %0b want 0", stb_o); end
    step();
    n_checks++; if (stb_o !== 1'b1 || adr_o !== 23'h1004) begin n_fail++; $display("FAIL bp_resume: got stb %0b adr %h want 1 1004", stb_o, adr_o); end
    pop_all(40);
    n_checks++; if (got_n != 9) begin n_fail++; $display("FAIL bp_count: got %0d want 9", got_n); end
    for (int k = 0; k < 9; k++) begin
      n_checks++; if (got[k] !== word_of(23'h1001 + 23'(k))) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", k + 1, got[k], word_of(23'h1001 + 23'(k))); end
    end
    n_checks++; if (ld_count - ld0 != 1) begin n_fail++; $display("FAIL bp_ld_count: got %0d want 1", ld_count - ld0); end
    $display("test_backpressure: done");
  endtask

  task automatic test_vsync_abort();
    len_i = 10'd8; ack_gate = 1'b1;
    do_vsync(23'h2000);
    hsync_pulse();
    repeat (3) step();
    n_checks++; if (fifo_valid_o !== 1'b1 || adr_o !== 23'h2003) begin n_fail++; $display("FAIL abort_pre: got valid %0b adr %h want 1 2003", fifo_valid_o, adr_o); end
    do_vsync(23'h2000);
    n_checks++; if (cyc_o !== 1'b0 || fifo_valid_o !== 1'b0 || adr_o !== 23'h2000) begin
      n_fail++; $display("FAIL abort_state: got cyc %0b valid %0b adr %h want 0 0 2000", cyc_o, fifo_valid_o, adr_o);
    end
    step();
    hsync_pulse();
    n_checks++; if (cyc_o !== 1'b1 || adr_o !== 23'h2000) begin n_fail++; $display("FAIL abort_restart: got cyc %0b adr %h want 1 2000", cyc_o, adr_o); end
    pop_all(30);
    n_checks++; if (got_n != 8 || got[0] !== word_of(23'h2000) || got[7] !== word_of(23'h2007)) begin
      n_fail++; $display("FAIL abort_line: got n=%0d w0=%h w7=%h want 8 %h %h", got_n, got[0], got[7], word_of(23'h2000), word_of(23'h2007));
    end
    $display("test_vsync_abort: done");
  endtask

  task automatic test_overrun();
    int ld0;
    len_i = 10'd8; stride_i = 10'h10; ack_gate = 1'b0;
    do_vsync(23'h3000);
    step();
    ld0 = ld_count;
    got_n = 0;
    for (int i = 0; i < 60; i++) begin
      hsync_i  = (i == 0 || i == 10);
      ack_gate = (i % 4 == 3);
      if (i == 14) begin
        n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %0b want 1", overrun_o); end
      end
      if (fifo_valid_o === 1'b1) begin
        got[got_n] = fifo_dat_o;
        got_n++;
        fifo_rd_i = 1'b1;
      end else begin
        fifo_rd_i = 1'b0;
      end
      step();
    end
    fifo_rd_i = 1'b0; ack_gate = 1'b1; hsync_i = 1'b0;
    n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b want 1", overrun_o); end
    n_checks++; if (got_n != 8) begin n_fail++; $display("FAIL ovr_count: got %0d want 8", got_n); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (got[k] !== word_of(23'h3000 + 23'(k))) begin n_fail++; $display("FAIL ovr_word%0d: got %h want %h", k, got[k], word_of(23'h3000 + 23'(k))); end
    end
    n_checks++; if (ld_count - ld0 != 1 || cyc_o !== 1'b0) begin n_fail++; $display("FAIL ovr_one_line: got lines %0d cyc %0b want 1 0", ld_count - ld0, cyc_o); end
    do_vsync(23'h3000);
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %0b want 0", overrun_o); end
    $display("test_overrun: done");
  endtask

  task automatic test_edges();
    int ld0;
    logic [AW-1:0] e;
    ack_gate = 1'b1; stride_i = 10'h40;
    do_vsync(23'h4000);
    step();
    ld0 = ld_count;
    len_i = 10'd0;
    hsync_pulse();
    n_checks++; if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL len0_cyc: got %0b want 0", cyc_o); end
    repeat (3) step();
    n_checks++; if (cyc_o !== 1'b0 || adr_o !== 23'h4000 || ld_count != ld0) begin
      n_fail++; $display("FAIL len0_idle: got cyc %0b adr %h lines %0d want 0 4000 0", cyc_o, adr_o, ld_count - ld0);
    end
    len_i = 10'd4;
    hsync_pulse();
    n_checks++; if (cyc_o !== 1'b1 || adr_o !== 23'h4000) begin n_fail++; $display("FAIL len0_lineadr: got cyc %0b adr %h want 1 4000", cyc_o, adr_o); end
    pop_all(10);
    den_i = 1'b0;
    hsync_pulse();
    n_checks++; if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL den0_cyc: got %0b want 0", cyc_o); end
    step();
    n_checks++; if (cyc_o !== 1'b0 || fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL den0_idle: got cyc %0b valid %0b want 0 0", cyc_o, fifo_valid_o); end
    den_i = 1'b1;
    do_vsync(23'h7FFFFE);
    step();
    hsync_pulse();
    e = 23'h7FFFFE;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (adr_o !== e) begin n_fail++; $display("FAIL wrap_adr%0d: got %h want %h", k, adr_o, e); end
      e = e + 23'd1;
      step();
    end
    n_checks++; if (adr_o !== 23'h000002) begin n_fail++; $display("FAIL wrap_end: got %h want 000002", adr_o); end
    pop_all(6);
    n_checks++; if (got_n != 4 || got[2] !== word_of(23'h0) || got[3] !== word_of(23'h1)) begin
      n_fail++; $display("FAIL wrap_data: got n=%0d w2=%h w3=%h want 4 %h %h", got_n, got[2], got[3], word_of(23'h0), word_of(23'h1));
    end
    $display("test_edges: done");
  endtask

  task automatic test_reset_mid_fetch();
    len_i = 10'd8; ack_gate = 1'b1;
    do_vsync(23'h5000);
    step();
    hsync_pulse();
    step(); step();
    hsync_pulse();
    n_checks++; if (overrun_o !== 1'b1 || cyc_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got ovr %0b cyc %0b want 1 1", overrun_o, cyc_o); end
    #2;
    reset_i = 1'b1;
    #1;
    n_checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_bus: got cyc %0b stb %0b want 0 0", cyc_o, stb_o); end
    n_checks++; if (adr_o !== '0 || fifo_valid_o !== 1'b0 || overrun_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_state: got adr %h valid %0b ovr %0b want 0 0 0", adr_o, fifo_valid_o, overrun_o);
    end
    step(); step();
    reset_i = 1'b0;
    repeat (3) step();
    n_checks++; if (cyc_o !== 1'b0 || fifo_valid_o !== 1'b0 || adr_o !== '0) begin
      n_fail++; $display("FAIL rst_after: got cyc %0b valid %0b adr %h want 0 0 0", cyc_o, fifo_valid_o, adr_o);
    end
    $display("test_reset_mid_fetch: done");
  endtask

  initial begin
    reset_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0; den_i = 1'b1;
    fb_adr_i = '0; len_i = '0; stride_i = '0; fifo_rd_i = 1'b0; ack_gate = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_vsync_abort();
    test_overrun();
    test_edges();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
